inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- PC register and instruction-fetch stage that consumes the next-PC value from the PC selector and drives instruction memory.
- Holds the architectural PC and runs a request/grant/response handshake with instruction memory.
- Presents one instruction at a time to decode/execute and raises the stall (waitt) back to the PC selector while a fetch is outstanding.
- Detects misaligned PCs and memory timeouts.

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset.
- TIMEOUT_CYCLES, 64, cycles allowed from grant to rvalid before a fetch fault.
- NOP_INSTR, 32'h00000013, instruction driven on fault (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- nextpc  in  32  next PC from the PC selector; sampled only on a retire cycle.
- retire  in  1  core has finished the presented instruction; single-cycle pulse.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; equals pc.
- imem_gnt  in  1  memory accepted the request.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- pc  out  32  PC of the presented instruction.
- instr  out  32  presented instruction.
- instr_valid  out  1  instr and pc are valid for the core.
- waitt  out  1  stall; high whenever instr_valid is low.
- fetch_fault  out  1  the presented instruction is a fault NOP.
- fault_cause  out  2  00 none, 01 misaligned PC, 10 timeout.

Behaviour:
- Reset (reset low, asynchronous):
  - pc=RESET_PC, state=ISSUE, imem_req=0, instr=NOP_INSTR, instr_valid=0, waitt=1, fetch_fault=0, fault_cause=00, timeout counter=0.
  - First request goes out on the first cycle after release.
- ISSUE:
  - If pc[1:0]!=0: no request is issued. Next cycle instr=NOP_INSTR, fetch_fault=1, fault_cause=01, go to HOLD.
  - Otherwise imem_req=1, imem_addr=pc. imem_req stays high and imem_addr stays stable until imem_gnt.
  - On gnt, go to WAIT with counter cleared.
  - gnt and rvalid in the same cycle: treat as gnt only. rvalid is legal no earlier than the cycle after gnt.
- WAIT:
  - imem_req=0; the counter increments each cycle.
  - On rvalid: capture imem_rdata into instr, instr_valid=1 next cycle, go to HOLD.
  - When the counter reaches TIMEOUT_CYCLES-1 without rvalid: instr=NOP_INSTR, fetch_fault=1, fault_cause=10, go to HOLD.
  - If rvalid arrives in the same cycle as the final count, rvalid wins.
  - A late rvalid arriving in HOLD or ISSUE after a timeout is dropped.
- HOLD:
  - instr_valid=1, waitt=0; instr and pc are held stable.
  - On retire: pc<=nextpc, instr_valid<=0, clear fetch_fault and fault_cause, go to ISSUE.
  - Minimum fetch-to-fetch spacing is 1 cycle in HOLD plus 1 cycle in ISSUE.
- retire outside HOLD is ignored; it does not update pc.
- waitt is the combinational inverse of instr_valid. The selector evaluates on negedge, so nextpc is settled at the retire posedge.
- Best-case latency from ISSUE (gnt immediate, rvalid next cycle) to instr_valid=1 is 2 cycles.
- Reset asserted mid-WAIT aborts the transaction. A response arriving after reset release is discarded, because the state is ISSUE and requires a new gnt first.
- pc arithmetic wraps modulo 2^32. No increment is done here; the next PC comes only from nextpc.

Decomposition:
- Shared package (cpu_pkg):
  - State enum {ISSUE, WAIT, HOLD}.
  - fault_cause constants FC_NONE/FC_MISALIGN/FC_TIMEOUT.
  - NOP_INSTR and RESET_PC constants.
- One natural sub-module: fetch_timeout_ctr. Counter with clear/enable and a terminal-count output, width $clog2(TIMEOUT_CYCLES).

Test Plan:
- Reset release, gnt on cycle 1, rvalid on cycle 2 with rdata=32'h00500093 -> imem_addr=32'h80000000; instr_valid=1 on cycle 3, instr=32'h00500093, waitt=0.
- In HOLD, retire with nextpc=32'h80000010 -> pc=32'h80000010, next request carries addr 32'h80000010. Hold gnt low for 3 cycles -> imem_req and imem_addr stay stable, waitt=1 throughout.
- retire with nextpc=32'h80000006 -> no imem_req; next cycle instr=32'h00000013, fetch_fault=1, fault_cause=01.
- Grant, withhold rvalid for 64 cycles -> fault_cause=10, instr=NOP. A rvalid at cycle 70 is ignored and instr is unchanged.
- rvalid on exactly the 64th WAIT cycle -> real data captured, fetch_fault=0.
- Assert reset 1 cycle after gnt, release, then inject a stray rvalid before any gnt -> discarded, pc=32'h80000000, fresh request issued.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [1:0]  FC_NONE     = 2'b00;
  localparam logic [1:0]  FC_MISALIGN = 2'b01;
  localparam logic [1:0]  FC_TIMEOUT  = 2'b10;

  localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF   = 32'h8000_0000;
  localparam int          TIMEOUT_DEF    = 64;

  function automatic logic pc_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/grant/response bus.
interface inst_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/inst_fetch_timeout_ctr.sv
// Grant-to-response cycle counter with clear, enable and terminal count.
module inst_fetch_timeout_ctr #(
  parameter int LIMIT = 64,
  localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q;

  // Clear dominates enable so a fresh grant always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign tc_o = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/inst_fetch.sv
// PC register and fetch FSM: issues one imem request per retired instruction
// and presents the response (or a fault NOP) to the core.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEF,
  parameter int          TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_fetch_if.master      imem,
  input  logic [31:0]       nextpc_i,
  input  logic              retire_i,
  output logic [31:0]       pc_o,
  output logic [31:0]       instr_o,
  output logic              instr_valid_o,
  output logic              waitt_o,
  output logic              fetch_fault_o,
  output logic [1:0]        fault_cause_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic         fault_q;
  logic [1:0]   cause_q;
  logic         req_q;
  logic         tc_s;

  inst_fetch_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q == ISSUE),
    .en_i  ((state_q == WAIT) && !imem.rvalid),
    .tc_o  (tc_s)
  );

  // Fetch FSM; req_q is computed alongside the transition into ISSUE so the
  // request is visible in the very first ISSUE cycle after a retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= FC_NONE;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        ISSUE: begin
          if (!pc_aligned(pc_q)) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b1;
            fault_q <= 1'b1;
            cause_q <= FC_MISALIGN;
            req_q   <= 1'b0;
            state_q <= HOLD;
          end else if (req_q && imem.gnt) begin
            req_q   <= 1'b0;
            state_q <= WAIT;
          end else begin
            req_q   <= 1'b1;
          end
        end
        WAIT: begin
          if (imem.rvalid) begin
            instr_q <= imem.rdata;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end else if (tc_s) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b1;
            fault_q <= 1'b1;
            cause_q <= FC_TIMEOUT;
            state_q <= HOLD;
          end else begin
            state_q <= WAIT;
          end
        end
        HOLD: begin
          if (retire_i) begin
            pc_q    <= nextpc_i;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= FC_NONE;
            req_q   <= pc_aligned(nextpc_i);
            state_q <= ISSUE;
          end else begin
            state_q <= HOLD;
          end
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          state_q <= ISSUE;
        end
      endcase
    end
  end

  assign imem.req      = req_q;
  assign imem.addr     = pc_q;
  assign pc_o          = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign waitt_o       = ~valid_q;
  assign fetch_fault_o = fault_q;
  assign fault_cause_o = cause_q;

endmodule
